cdc_fifo_write_arbiter: RTL

//  Shares the single write port of a CDC FIFO among NUM_REQUESTERS write-clock-domain sources.

---
 rtl/cdc_fifo_pkg.sv | 8 +
 rtl/rr_priority_picker.sv | 35 +++
 rtl/cdc_fifo_write_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/cdc_fifo_pkg.sv
// cdc_fifo_pkg: shared types and sizing helpers for the CDC FIFO write and read sides.
package cdc_fifo_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  // Source id width; read-side logic uses the same function so tags line up.
  function automatic int src_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request at or after pointer, wrapping modulo N.
module rr_priority_picker
  import cdc_fifo_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = src_id_width(N)
) (
  input  logic [N-1:0]  requests,
  input  logic [PW-1:0] pointer,
  output logic [PW-1:0] winner,
  output logic          found
);
  localparam logic [PW:0] NW = N[PW:0];
  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [PW-1:0]  offset;
  logic [PW:0]    sum;
  logic [PW:0]    wrapped;
  always_comb begin
    doubled = {requests, requests} >> pointer;
    rotated = doubled[N-1:0];
    offset = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = i[PW-1:0];
        found = 1'b1;
      end
    end
    // Explicit wrap so non-power-of-2 counts never index past N-1.
    sum = {1'b0, pointer} + {1'b0, offset};
    wrapped = (sum >= NW) ? sum - NW : sum;
    winner = wrapped[PW-1:0];
  end
endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// cdc_fifo_write_arbiter: packet-granular round-robin sharing of a CDC FIFO write port.
module cdc_fifo_write_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQUESTERS-1:0]              req_last,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  input  logic                                   full,
  output logic                                   write_increment,
  output logic [DATA_WIDTH-1:0]                  write_data,
  output logic [src_id_width(NUM_REQUESTERS)-1:0] write_source,
  output logic [NUM_REQUESTERS-1:0]              grant,
  output logic                                   busy
);
  localparam int NR = NUM_REQUESTERS;
  localparam int SW = src_id_width(NUM_REQUESTERS);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_t    state_q, state_d;
  logic [NR-1:0] grant_q, grant_d;
  logic [SW-1:0] source_q, source_d;
  logic [BW-1:0] beat_count_q, beat_count_d;
  logic [SW-1:0] rr_pointer_q, rr_pointer_d;
  logic [SW-1:0] winner;
  logic          found;
  logic          fire;
  logic          release_grant;

  rr_priority_picker #(.N(NR), .PW(SW)) u_picker (
    .requests (req_valid),
    .pointer  (rr_pointer_q),
    .winner   (winner),
    .found    (found)
  );

  always_comb begin
    busy = state_q == ARB_BURST;
    fire = busy & req_valid[source_q] & ~full;
    release_grant = fire & (req_last[source_q] | (beat_count_q == BW'(MAX_BURST - 1)));
    req_ready = (busy & ~full) ? grant_q : '0;
    write_increment = fire;
    write_data = req_data[int'(source_q)*DATA_WIDTH +: DATA_WIDTH];
    write_source = source_q;
    grant = grant_q;
    state_d = state_q;
    grant_d = grant_q;
    source_d = source_q;
    beat_count_d = beat_count_q;
    rr_pointer_d = rr_pointer_q;
    if (!busy && found) begin
      state_d = ARB_BURST;
      source_d = winner;
      grant_d = NR'(1) << winner;
    end else if (release_grant) begin
      // Forced release at MAX_BURST re-arbitrates the packet remainder like a fresh request.
      state_d = ARB_IDLE;
      grant_d = '0;
      beat_count_d = '0;
      rr_pointer_d = (source_q == SW'(NR - 1)) ? '0 : source_q + 1'b1;
    end else if (fire) begin
      beat_count_d = beat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      source_q <= '0;
      beat_count_q <= '0;
      rr_pointer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      source_q <= source_d;
      beat_count_q <= beat_count_d;
      rr_pointer_q <= rr_pointer_d;
    end
  end
endmodule
